// File: rtl/gan_param_loader.sv
// gan_param_loader: valid/ready serial-in, parallel-out loader for the GAN
// weight/bias bank.
// Ports: clock/reset (async, active-low), reload (sync restart);
// s_data/s_valid/s_ready (input word stream); params (flat bank),
// params_valid (full frame held, drives GAN enable), load_idx (next slot),
// param_err (checksum mismatch).
// Optional feature: define PARAM_CHECKSUM_EN to expect a trailing
// modulo-2^WIDTH checksum word after the last parameter.
module gan_param_loader #(
  parameter int WIDTH      = 6,
  parameter int NUM_PARAMS = 73,
  parameter int IDX_W      = 7
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        reload,
  input  logic [WIDTH-1:0]            s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [NUM_PARAMS*WIDTH-1:0] params,
  output logic                        params_valid,
  output logic [IDX_W-1:0]            load_idx,
  output logic                        param_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DONE  = 3'd2;
`ifdef PARAM_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
`endif

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PARAMS - 1);

  logic [2:0]                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        pv_q, pv_d;
  logic [NUM_PARAMS*WIDTH-1:0] bank_q, bank_d;
  logic                        xfer;
  logic                        ready_st;

`ifdef PARAM_CHECKSUM_EN
  logic [WIDTH-1:0]            sum_q, sum_d;
  logic                        err_q, err_d;

  assign ready_st  = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign param_err = err_q;
`else
  assign ready_st  = (state_q == S_LOAD);
  assign param_err = 1'b0;
`endif

  // reload always wins over a handshake in the same cycle
  assign s_ready = ready_st && !reload;
  assign xfer    = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pv_d    = pv_q;
    bank_d  = bank_q;
`ifdef PARAM_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    if (reload && (state_q != S_IDLE)) begin
      state_d = S_LOAD;
      idx_d   = '0;
      pv_d    = 1'b0;
`ifdef PARAM_CHECKSUM_EN
      sum_d   = '0;
      err_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_LOAD;
        S_LOAD: begin
          if (xfer) begin
            bank_d[int'(idx_q)*WIDTH +: WIDTH] = s_data;
`ifdef PARAM_CHECKSUM_EN
            sum_d = sum_q + s_data;
`endif
            if (idx_q == LAST) begin
`ifdef PARAM_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
              pv_d    = 1'b1;
`endif
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
`ifdef PARAM_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            if (s_data == sum_q) begin
              state_d = S_DONE;
              pv_d    = 1'b1;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end
        S_ERR:  state_d = S_ERR;
`endif
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pv_q    <= 1'b0;
      bank_q  <= '0;
`ifdef PARAM_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pv_q    <= pv_d;
      bank_q  <= bank_d;
`ifdef PARAM_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign params       = bank_q;
  assign params_valid = pv_q;
  assign load_idx     = idx_q;

endmodule

// File: tb/tb_gan_param_loader.sv
// tb_gan_param_loader: directed bench for gan_param_loader.
// Spot-check table plus hand-written reload/reset/checksum sequences.
module tb_gan_param_loader;

  localparam int W  = 6;
  localparam int NP = 73;
  localparam int IW = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic          reload;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [NP*W-1:0] params;
  logic          params_valid;
  logic [IW-1:0] load_idx;
  logic          param_err;

  int errors = 0;
  int checks = 0;

  gan_param_loader #(.WIDTH(W), .NUM_PARAMS(NP), .IDX_W(IW)) dut (
    .clock(clock),
    .reset(reset),
    .reload(reload),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .params(params),
    .params_valid(params_valid),
    .load_idx(load_idx),
    .param_err(param_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         idx;
    logic [5:0] exp;
  } spot_t;

  spot_t spots[8];

  function automatic logic [5:0] wgt(int i);
    case (i)
      0:  return 6'd6;
      1:  return 6'd21;
      72: return 6'b110110;
      default: return 6'((i * 7 + 3) % 64);
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [5:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic check_spots();
    for (int k = 0; k < 8; k++)
      chk($sformatf("spot_%0d", spots[k].idx),
          64'(params[spots[k].idx*W +: W]), 64'(spots[k].exp));
  endtask

  task automatic check_bank_wgt(string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < NP; i++)
      if (params[i*W +: W] !== wgt(i)) bad++;
    chk(nm, 64'(bad), 64'd0);
  endtask

  function automatic logic [5:0] wgt_sum();
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < NP; i++) s = s + wgt(i);
    return s;
  endfunction

  initial begin
    spots[0] = '{0,  6'd6};
    spots[1] = '{1,  6'd21};
    spots[2] = '{2,  6'd17};
    spots[3] = '{10, 6'd9};
    spots[4] = '{40, 6'd27};
    spots[5] = '{50, 6'd33};
    spots[6] = '{71, 6'd52};
    spots[7] = '{72, 6'b110110};

    reset   = 1'b0;
    reload  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) step();
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_pv", 64'(params_valid), 64'd0);
    chk("rst_idx", 64'(load_idx), 64'd0);
    chk("rst_params", 64'(|params), 64'd0);
    chk("rst_err", 64'(param_err), 64'd0);

    reset = 1'b1;
    #1;
    chk("idle_ready", 64'(s_ready), 64'd0);
    step();
    chk("load_ready", 64'(s_ready), 64'd1);
    chk("load_idx0", 64'(load_idx), 64'd0);

    // back-to-back frame of GAN weights
    for (int i = 0; i < NP - 1; i++) send_word(wgt(i));
    chk("pre_last_idx", 64'(load_idx), 64'd72);
    chk("pre_last_pv", 64'(params_valid), 64'd0);
    send_word(wgt(NP - 1));
`ifdef PARAM_CHECKSUM_EN
    chk("ck_wait_pv", 64'(params_valid), 64'd0);
    send_word(wgt_sum());
`endif
    chk("frame_pv", 64'(params_valid), 64'd1);
    chk("frame_ready", 64'(s_ready), 64'd0);
    chk("frame_idx_sat", 64'(load_idx), 64'd72);
    chk("word0", 64'(params[5:0]), 64'd6);
    chk("word72", 64'(params[437:432]), 64'b110110);
    check_spots();
    check_bank_wgt("bank_frame1");

    // stray words while DONE are ignored
    send_word(6'd63);
    chk("done_ign_idx", 64'(load_idx), 64'd72);
    chk("done_ign_pv", 64'(params_valid), 64'd1);
    check_bank_wgt("bank_done_ign");

    // reload mid-frame at index 40 with a word offered
    do_reload();
    chk("rl_idx", 64'(load_idx), 64'd0);
    chk("rl_pv", 64'(params_valid), 64'd0);
    for (int i = 0; i < 40; i++) send_word(6'd5);
    chk("rl_idx40", 64'(load_idx), 64'd40);
    reload  = 1'b1;
    s_valid = 1'b1;
    s_data  = 6'd33;
    #1;
    chk("rl_ready_low", 64'(s_ready), 64'd0);
    step();
    reload  = 1'b0;
    s_valid = 1'b0;
    chk("rl_drop_idx", 64'(load_idx), 64'd0);
    chk("rl_keep_bank", 64'(params[40*W +: W]), 64'd27);
    for (int i = 0; i < NP; i++) send_word(6'd5);
`ifdef PARAM_CHECKSUM_EN
    send_word(6'd45);
`endif
    chk("fives_pv", 64'(params_valid), 64'd1);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < NP; i++)
        if (params[i*W +: W] !== 6'd5) bad++;
      chk("fives_bank", 64'(bad), 64'd0);
    end

    // pseudo-random s_valid gaps
    do_reload();
    begin
      int n;
      int cyc;
      bit hs;
      n = 0;
      cyc = 0;
      while (n < NP && cyc < 2000) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = wgt(n);
        hs = s_valid && s_ready;
        step();
        if (hs) n++;
        chk("rand_idx", 64'(load_idx), 64'((n > NP - 1) ? NP - 1 : n));
        cyc++;
      end
      s_valid = 1'b0;
      chk("rand_done", 64'(n), 64'(NP));
    end
`ifdef PARAM_CHECKSUM_EN
    send_word(wgt_sum());
`endif
    chk("rand_pv", 64'(params_valid), 64'd1);
    check_spots();
    check_bank_wgt("bank_rand");

`ifdef PARAM_CHECKSUM_EN
    do_reload();
    for (int i = 0; i < NP; i++) send_word(6'd1);
    chk("ck_hold_pv", 64'(params_valid), 64'd0);
    send_word(6'd9);
    chk("ck_ok_pv", 64'(params_valid), 64'd1);
    chk("ck_ok_err", 64'(param_err), 64'd0);
    do_reload();
    for (int i = 0; i < NP; i++) send_word(6'd1);
    send_word(6'd10);
    chk("ck_bad_err", 64'(param_err), 64'd1);
    chk("ck_bad_pv", 64'(params_valid), 64'd0);
    chk("ck_bad_ready", 64'(s_ready), 64'd0);
    do_reload();
    chk("ck_rl_err", 64'(param_err), 64'd0);
    chk("ck_rl_ready", 64'(s_ready), 64'd1);
`endif

    // asynchronous reset mid-frame
    do_reload();
    for (int i = 0; i < 20; i++) send_word(wgt(i));
    chk("ar_idx20", 64'(load_idx), 64'd20);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_idx", 64'(load_idx), 64'd0);
    chk("ar_params", 64'(|params), 64'd0);
    chk("ar_pv", 64'(params_valid), 64'd0);
    chk("ar_ready", 64'(s_ready), 64'd0);
    chk("ar_err", 64'(param_err), 64'd0);
    step();
    reset = 1'b1;
    step();
    chk("ar_back_ready", 64'(s_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
